// File: rtl/ppu_palette_arbiter.sv
// ppu_palette_arbiter: shares the palette port between renderer lookups and buffered CPU accesses
module ppu_palette_arbiter #(
  parameter int WFIFO_DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rend_req,
  input  logic [4:0] rend_addr,
  output logic [7:0] rend_color,
  output logic       rend_valid,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_busy,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  output logic       cpu_ovf,
  output logic       pal_en,
  output logic       pal_rw,
  output logic [4:0] pal_addr,
  output logic [7:0] pal_wdata,
  input  logic [7:0] pal_rdata
);
  typedef enum logic [1:0] {IDLE, DRAIN, RD} state_t;
  state_t state;
  logic [12:0] fifo [WFIFO_DEPTH];
  logic [12:0] head;
  logic [PTR_W:0] wptr, rptr, wptr_n, rptr_n;
  logic [4:0] rd_addr;
  logic pend, pend_n, empty, empty_n, full, push, rd_acc, wr_gnt, rd_gnt;
  // FIFO status, grants and palette port mux; the renderer always wins the port
  always_comb begin
    empty = wptr == rptr;
    full = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    cpu_busy = full || pend;
    push = cpu_req && cpu_we && !cpu_busy;
    rd_acc = cpu_req && !cpu_we && !cpu_busy;
    wr_gnt = state == DRAIN && !rend_req && !empty;
    rd_gnt = state == RD && !rend_req;
    wptr_n = wptr + (PTR_W+1)'(push);
    rptr_n = rptr + (PTR_W+1)'(wr_gnt);
    empty_n = wptr_n == rptr_n;
    pend_n = (pend && !rd_gnt) || rd_acc;
    head = fifo[rptr[PTR_W-1:0]];
    pal_en = rend_req || wr_gnt || rd_gnt;
    pal_rw = wr_gnt;
    pal_addr = rend_req ? rend_addr : wr_gnt ? head[12:8] : rd_gnt ? rd_addr : 5'd0;
    pal_wdata = wr_gnt ? head[7:0] : 8'd0;
  end
  // write buffer storage, contents are meaningful only between the pointers
  always_ff @(posedge clk)
    if (push) fifo[wptr[PTR_W-1:0]] <= {cpu_addr, cpu_wdata};
  // renderer return path and FIFO pointers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rend_color <= '0;
      rend_valid <= 1'b0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      rend_valid <= rend_req;
      if (rend_req) rend_color <= pal_rdata;
      wptr <= wptr_n;
      rptr <= rptr_n;
    end
  // CPU control: decisions use post-edge FIFO/pending status so work starts the next cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pend <= 1'b0;
      rd_addr <= '0;
      cpu_rdata <= '0;
      cpu_rvalid <= 1'b0;
      cpu_ovf <= 1'b0;
    end else begin
      state <= (state == RD) ? (rd_gnt ? IDLE : RD) : !empty_n ? DRAIN : pend_n ? RD : IDLE;
      pend <= pend_n;
      if (rd_acc) rd_addr <= cpu_addr;
      if (rd_gnt) cpu_rdata <= pal_rdata;
      cpu_rvalid <= rd_gnt;
      if (cpu_req && cpu_busy) cpu_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_ppu_palette_arbiter.sv
// tb_ppu_palette_arbiter: directed and random checks of the palette arbiter against a queue model
module tb_ppu_palette_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rend_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0] rend_addr = '0, cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] rend_color, cpu_rdata, pal_wdata, pal_rdata;
  logic rend_valid, cpu_busy, cpu_rvalid, cpu_ovf, pal_en, pal_rw;
  logic [4:0] pal_addr;

  ppu_palette_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rend_req(rend_req), .rend_addr(rend_addr),
    .rend_color(rend_color), .rend_valid(rend_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_ovf(cpu_ovf), .pal_en(pal_en), .pal_rw(pal_rw),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  logic [7:0] shadow [32];
  assign pal_rdata = mem[pal_addr];
  always @(posedge clk) if (pal_en && pal_rw) mem[pal_addr] <= pal_wdata;

  logic [12:0] wq [$];
  bit rd_pend_m = 0, ovf_m = 0;
  logic [4:0] rd_addr_m = '0;
  logic [7:0] rd_exp_m = '0;
  int errors = 0, checks = 0, wr_seen = 0, rd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rr, input logic [4:0] ra, input logic cr, input logic cw,
                      input logic [4:0] ca, input logic [7:0] cd);
    bit busy_m, rd_iss, ev;
    logic [7:0] ec;
    rend_req = rr; rend_addr = ra; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    #1;
    busy_m = (wq.size() == 4) || rd_pend_m;
    chk("cpu_busy", {31'd0, cpu_busy}, {31'd0, busy_m});
    rd_iss = 0;
    if (rr) begin
      chk("rend_port", {pal_en, pal_rw, pal_addr}, {1'b1, 1'b0, ra});
    end else if (pal_en && pal_rw) begin
      chk("wr_expected", {31'd0, wq.size() != 0}, 32'd1);
      if (wq.size() != 0) begin
        chk("wr_entry", {19'd0, pal_addr, pal_wdata}, {19'd0, wq[0]});
        wq.delete(0);
      end
      wr_seen++;
    end else if (pal_en) begin
      chk("rd_order", {30'd0, rd_pend_m, wq.size() == 0}, 32'd3);
      chk("rd_addr", {27'd0, pal_addr}, {27'd0, rd_addr_m});
      rd_iss = 1;
    end else begin
      chk("idle_port", {18'd0, pal_rw, pal_addr, pal_wdata}, 32'd0);
    end
    ev = rr;
    ec = mem[ra];
    if (cr) begin
      if (busy_m) ovf_m = 1;
      else if (cw) begin wq.push_back({ca, cd}); shadow[ca] = cd; end
      else begin rd_pend_m = 1; rd_addr_m = ca; rd_exp_m = shadow[ca]; end
    end
    @(posedge clk);
    @(negedge clk);
    chk("rend_valid", {31'd0, rend_valid}, {31'd0, ev});
    if (ev) chk("rend_color", {24'd0, rend_color}, {24'd0, ec});
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, rd_iss});
    if (rd_iss) begin
      chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, rd_exp_m});
      rd_pend_m = 0;
      rd_seen++;
    end
    chk("cpu_ovf", {31'd0, cpu_ovf}, {31'd0, ovf_m});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a"}, {15'd0, rend_color, rend_valid, cpu_rdata}, 32'd0);
    chk({tag, "_b"}, {8'd0, cpu_busy, cpu_rvalid, cpu_ovf, pal_en, pal_rw, pal_addr, pal_wdata}, 32'd0);
  endtask

  initial begin
    int w0, r0, n;
    bit blank;
    for (int i = 0; i < 32; i++) begin mem[i] = 8'(i * 7 + 3); shadow[i] = 8'(i * 7 + 3); end
    mem[0] = 8'h0F; mem[1] = 8'h21; mem[2] = 8'h30;
    shadow[0] = 8'h0F; shadow[1] = 8'h21; shadow[2] = 8'h30;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // renderer only: back-to-back lookups
    step(1, 0, 0, 0, 0, 0); chk("rend0", {24'd0, rend_color}, 32'h0F);
    step(1, 1, 0, 0, 0, 0); chk("rend1", {24'd0, rend_color}, 32'h21);
    step(1, 2, 0, 0, 0, 0); chk("rend2", {24'd0, rend_color}, 32'h30);
    // single write drains while renderer idle
    w0 = wr_seen;
    step(0, 0, 1, 1, 5, 8'h16);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_one", wr_seen - w0, 1);
    chk("drain_mem", {24'd0, mem[5]}, 32'h16);
    // renderer priority over two buffered writes
    w0 = wr_seen;
    step(1, 3, 1, 1, 7, 8'hA1);
    step(1, 4, 1, 1, 8, 8'hB2);
    for (int i = 0; i < 10; i++) step(1, 5'(i), 0, 0, 0, 0);
    chk("prio_hold", wr_seen - w0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("prio_drain", wr_seen - w0, 2);
    // read after write returns the buffered value
    r0 = rd_seen;
    step(0, 0, 1, 1, 3, 8'h2A);
    step(0, 0, 1, 0, 3, 0);
    n = 0;
    while (rd_seen == r0 && n < 10) begin step(0, 0, 0, 0, 0, 0); n++; end
    chk("raw_done", rd_seen - r0, 1);
    chk("raw_data", {24'd0, cpu_rdata}, 32'h2A);
    step(0, 0, 0, 0, 0, 0);
    // fill the FIFO behind the renderer, then overflow
    w0 = wr_seen;
    for (int i = 0; i < 4; i++) step(1, 5'(i), 1, 1, 5'(10 + i), 8'(8'h40 + i));
    #1 chk("full_busy", {31'd0, cpu_busy}, 32'd1);
    step(1, 0, 1, 1, 20, 8'hEE);
    chk("ovf_set", {31'd0, cpu_ovf}, 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    chk("full_drain", wr_seen - w0, 4);
    // randomized traffic with blanking windows
    blank = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) blank = ($urandom_range(0, 1) == 1);
      step(blank ? 1'b0 : ($urandom_range(0, 3) != 0), 5'($urandom), ($urandom_range(0, 2) == 0),
           1'($urandom), 5'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 0);
    chk("rand_flushed", {30'd0, wq.size() == 0, !rd_pend_m}, 32'd3);
    // reset mid-operation discards queued writes and pending read
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 5'(i), 8'hC0);
    step(1, 0, 1, 0, 1, 0);
    rend_req = 0; cpu_req = 0;
    rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    wq.delete(); rd_pend_m = 0; ovf_m = 0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) shadow[i] = mem[i];
    rst_n = 1'b1;
    w0 = wr_seen; r0 = rd_seen;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    chk("post_reset_quiet", {wr_seen - w0} + {rd_seen - r0}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ppu_palette_arbiter.md
Name: ppu_palette_arbiter

Overview:
- Single-port arbiter for the PPU palette memory (32 x 8).
- Shares the port between the pixel renderer (colour lookups, absolute priority) and the CPU data-port path (PPUDATA accesses in the $3F00-$3FFF range).
- CPU writes are buffered in a small FIFO and drained in cycles the renderer leaves idle; CPU reads are held pending until all earlier writes have drained.
- Sits between the PPU register block and the renderer on one side and the palette memory on the other.

Parameters:
- WFIFO_DEPTH, 4, number of buffered CPU writes (power of 2, >= 2).
- PTR_W, 2, log2(WFIFO_DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- rend_req  in  1  renderer requests a palette lookup this cycle
- rend_addr  in  5  renderer palette index
- rend_color  out  8  registered colour returned to the renderer
- rend_valid  out  1  rend_color is valid (one-cycle pulse)
- cpu_req  in  1  CPU access strobe (one cycle)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  5  CPU palette index
- cpu_wdata  in  8  CPU write data
- cpu_busy  out  1  arbiter cannot accept a cpu_req this cycle
- cpu_rdata  out  8  CPU read data
- cpu_rvalid  out  1  cpu_rdata is valid (one-cycle pulse)
- cpu_ovf  out  1  sticky flag: a cpu_req arrived while cpu_busy was high
- pal_en  out  1  palette memory enable
- pal_rw  out  1  palette memory direction, 1 = write
- pal_addr  out  5  palette memory address
- pal_wdata  out  8  palette memory write data
- pal_rdata  in  8  palette memory read data, combinational, same cycle as address

Behaviour:
- Reset values: all outputs 0. FIFO empty, no read pending, state IDLE.
- Reset asserted mid-operation: the FIFO is discarded, any pending read is dropped, and no cpu_rvalid is produced.
- Port outputs are combinational from the current grant:
  - rend_req high: pal_en=1, pal_rw=0, pal_addr=rend_addr.
  - Otherwise the CPU grant, if any, drives the port.
  - Otherwise pal_en=0 and pal_rw, pal_addr, pal_wdata are 0.
- Renderer timing:
  - Granted every cycle it requests; never stalled.
  - pal_rdata is captured into rend_color at the clock edge; rend_valid is high the next cycle.
  - Latency is exactly 1 cycle, fully pipelined, back-to-back lookups supported.
- cpu_busy = FIFO full OR read pending.
- cpu_req handling:
  - cpu_req with cpu_busy=1: ignored and sets cpu_ovf. cpu_ovf is cleared only by reset.
  - Write: {addr, wdata} is pushed into the FIFO at the clock edge.
  - Read: the address is latched and the read-pending bit is set.
- State machine:
  - IDLE: leave to DRAIN when the FIFO is non-empty; else to RD when a read is pending.
  - DRAIN: in each cycle with rend_req=0, drive the FIFO head (pal_en=1, pal_rw=1) and pop at the edge. Leave to RD when the FIFO becomes empty and a read is pending; else to IDLE when the FIFO becomes empty.
  - RD: in the first cycle with rend_req=0, drive a read; capture pal_rdata into cpu_rdata, clear pending, pulse cpu_rvalid the next cycle. Then go to IDLE.
- Ordering: reads never pass earlier writes. A read of an address with a buffered write returns the new value.
- Simultaneous push and pop in the same cycle: allowed; occupancy is unchanged. With the FIFO full, a pop frees one slot at the next cycle, not the same one.
- A new cpu_req is accepted in the cycle cpu_rvalid pulses (busy has dropped).
- FIFO pointers are PTR_W+1 bits and wrap modulo 2*WFIFO_DEPTH. Full/empty is decided by comparing the MSBs and the remaining bits.
- Addresses pass through unmodified; the palette memory handles its own mirroring.
- Renderer-busy cycles cause CPU work to wait indefinitely. There is no starvation guard: software accesses the palette only in blanking.

Test Plan:
- Renderer only: rend_req=1 for addrs 0,1,2 on consecutive cycles, memory returns 8'h0F/8'h21/8'h30 → rend_valid high on cycles 1-3 with the same values in order; pal_rw stays 0.
- CPU write drain with renderer idle: write addr 5 = 8'h16 → FIFO holds one entry; next cycle pal_en=1, pal_rw=1, pal_addr=5, pal_wdata=8'h16; pal_en=0 afterwards.
- Priority: FIFO holds 2 writes and rend_req is held high 10 cycles → no pal_rw=1 during those 10 cycles. Both writes issue in the 2 cycles after rend_req drops, in push order.
- Read after write: write addr 3 = 8'h2A, then read addr 3 with rend_req idle → cpu_busy high while pending. The write reaches memory before the read is issued; cpu_rvalid pulses once with cpu_rdata=8'h2A.
- Full and overflow: 4 writes with rend_req held high → cpu_busy=1. A 5th cpu_req is dropped and cpu_ovf=1. After rend_req drops, exactly 4 writes issue.
- Reset mid-operation: 3 writes queued and a read pending, rst_n pulsed low → all outputs 0 immediately. No memory writes and no cpu_rvalid follow reset release.
